// File: rtl/chan_mux_rr.sv
// Registered N-channel valid/ready multiplexer with fixed-select or round-robin grant.
// Optional MUX_CH_TAG_EN adds out_ch, the source channel of the held word.
module chan_mux_rr #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data
`ifdef MUX_CH_TAG_EN
  ,
  output logic [SEL_W-1:0]         out_ch
`endif
);

  localparam int unsigned CNT_W = SEL_W + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
`ifdef MUX_CH_TAG_EN
  logic [SEL_W-1:0]    ch_q, ch_d;
`endif

  logic                slot_free;
  logic                sel_ok;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic [CNT_W-1:0]    cand;
  logic [NUM_CH-1:0]   grant_oh;
  logic [DATA_W-1:0]   grant_data;
  logic                xfer;

  // Grant index: external select (range-checked) or first valid channel from rr_ptr.
  always_comb begin
    sel_ok    = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) sel_ok = 1'b1;
    end
    if (!mode) begin
      if (sel_ok) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cand = {1'b0, rr_ptr_q} + CNT_W'(k);
        if (cand >= CNT_W'(NUM_CH)) cand = cand - CNT_W'(NUM_CH);
        if (!grant_vld && in_valid[cand[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  // One-hot grant and the granted channel's data.
  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_vld && (grant_idx == SEL_W'(i))) begin
        grant_oh[i] = 1'b1;
        grant_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The slot accepts a new word when empty or when the held word leaves this cycle.
  assign slot_free = (state_q == ST_EMPTY) || out_ready;
  assign in_ready  = slot_free ? grant_oh : '0;
  assign xfer      = |(in_ready & in_valid);

  // Slot FSM next-state and payload/pointer update.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MUX_CH_TAG_EN
    ch_d     = ch_q;
`endif
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      data_d = grant_data;
`ifdef MUX_CH_TAG_EN
      ch_d   = grant_idx;
`endif
      if (mode) begin
        rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      rr_ptr_q <= '0;
`ifdef MUX_CH_TAG_EN
      ch_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MUX_CH_TAG_EN
      ch_q     <= ch_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
`ifdef MUX_CH_TAG_EN
  assign out_ch    = ch_q;
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: a 4-channel instance driven against a cycle model,
// plus a 3-channel instance for the out-of-range select and non-power-of-two wrap.
module tb_chan_mux_rr;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid, in_ready;
  logic                     mode, out_ready, out_valid;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
`ifdef MUX_CH_TAG_EN
  logic [SEL_W-1:0]         out_ch;
`endif

  logic [3*DATA_W-1:0] in_data3;
  logic [2:0]          in_valid3, in_ready3;
  logic                mode3, out_ready3, out_valid3;
  logic [1:0]          sel3;
  logic [DATA_W-1:0]   out_data3;
`ifdef MUX_CH_TAG_EN
  logic [1:0]          out_ch3;
`endif

  chan_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data)
`ifdef MUX_CH_TAG_EN
    , .out_ch(out_ch)
`endif
  );

  chan_mux_rr #(.NUM_CH(3), .DATA_W(DATA_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_ready(out_ready3), .out_valid(out_valid3), .out_data(out_data3)
`ifdef MUX_CH_TAG_EN
    , .out_ch(out_ch3)
`endif
  );

  typedef struct packed {
    logic [SEL_W-1:0]  ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;
  exp_t              sb_q[$];
  logic              m_full;
  int unsigned       m_ptr;
  exp_t              m_last;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  logic [DATA_W-1:0] exp3_data [5] = '{8'h21, 8'h20, 8'h21, 8'h22, 8'h20};
  logic [1:0]        exp3_ch   [5] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle of stimulus on the 4-channel instance, checked against the model.
  task automatic step(input logic m, input logic [SEL_W-1:0] s, input logic [NUM_CH-1:0] v,
                      input logic rdy);
    logic              slot_free, gv;
    int unsigned       g, idx;
    logic [NUM_CH-1:0] exp_rdy;
    exp_t              front;
    @(negedge clk);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = ch_data[i];
    #1;
    slot_free = !m_full || rdy;
    gv = 1'b0;
    g  = 0;
    if (!m) begin
      if (s < NUM_CH) begin
        gv = 1'b1;
        g  = s;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (m_ptr + k) % NUM_CH;
        if (!gv && v[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
    exp_rdy = '0;
    if (slot_free && gv) exp_rdy[g] = 1'b1;
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(m_full));
    if (m_full && sb_q.size() > 0) begin
      front = rdy ? sb_q.pop_front() : sb_q[0];
      check_eq("out_data", 64'(out_data), 64'(front.data));
`ifdef MUX_CH_TAG_EN
      check_eq("out_ch", 64'(out_ch), 64'(front.ch));
`endif
    end else if (!m_full) begin
      check_eq("out_data_hold", 64'(out_data), 64'(m_last.data));
`ifdef MUX_CH_TAG_EN
      check_eq("out_ch_hold", 64'(out_ch), 64'(m_last.ch));
`endif
    end
    check_eq("oor_ready3", 64'(in_ready3), 64'd0);
    check_eq("oor_valid3", 64'(out_valid3), 64'd0);
    // Model state after the coming rising edge.
    if (gv && v[g] && slot_free) begin
      m_last = exp_t'{ch: SEL_W'(g), data: ch_data[g]};
      sb_q.push_back(m_last);
      m_full = 1'b1;
      if (m) m_ptr = (g + 1) % NUM_CH;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    m_last = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = '0;
    mode3     = 1'b0;
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    out_ready3 = 1'b1;
    in_data3  = {8'h22, 8'h21, 8'h20};
    ch_data   = '{8'h10, 8'h11, 8'hA5, 8'h13};
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
`ifdef MUX_CH_TAG_EN
    check_eq("rst_out_ch", 64'(out_ch), 64'd0);
`endif
    check_eq("rst_out_valid3", 64'(out_valid3), 64'd0);
    #2 rst_n = 1'b1;

    // Fixed select of channel 2.
    step(1'b0, 2'd2, 4'b0100, 1'b1);
    step(1'b0, 2'd2, 4'b0000, 1'b1);
    check_eq("sel2_data", 64'(out_data), 64'hA5);
    step(1'b0, 2'd2, 4'b0000, 1'b1);

    // Round-robin with every channel valid: 10,11,12,13,10,...
    ch_data[2] = 8'h12;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd0, 4'b1111, 1'b1);
      if (i > 0) check_eq("rr_seq", 64'(out_data), 64'(8'h10 + DATA_W'((i - 1) % 4)));
    end

    // Back-pressure while select and mode toggle.
    step(1'b1, 2'd0, 4'b0010, 1'b1);
    step(1'b0, 2'd3, 4'b1111, 1'b0);
    check_eq("bp_data0", 64'(out_data), 64'h11);
    step(1'b1, 2'd0, 4'b1111, 1'b0);
    check_eq("bp_data1", 64'(out_data), 64'h11);
    step(1'b0, 2'd1, 4'b1111, 1'b0);
    check_eq("bp_data2", 64'(out_data), 64'h11);
    step(1'b0, 2'd2, 4'b0100, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_eq("bp_reload", 64'(out_data), 64'h12);

    // Lone channel 3 with rr_ptr at 1, then drain and confirm the pointer wrapped to 0.
    step(1'b1, 2'd0, 4'b0001, 1'b1);
    step(1'b1, 2'd0, 4'b1000, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_eq("ch3_data", 64'(out_data), 64'h13);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_eq("ptr_wrap0", 64'(out_data), 64'h10);

    // Asynchronous reset while a word is held.
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = '0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
`ifdef MUX_CH_TAG_EN
    check_eq("arst_out_ch", 64'(out_ch), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    check_eq("arst_first_grant", 64'(out_data), 64'h10);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);

    // Three-channel instance: in-range select, then round-robin wrap 2 -> 0.
    @(negedge clk);
    sel3 = 2'd1;
    #1;
    check_eq("c3_ready_sel1", 64'(in_ready3), 64'(3'b010));
    check_eq("c3_valid_sel1", 64'(out_valid3), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mode3 = 1'b1;
      #1;
      check_eq("c3_out_valid", 64'(out_valid3), 64'd1);
      check_eq("c3_out_data", 64'(out_data3), 64'(exp3_data[i]));
`ifdef MUX_CH_TAG_EN
      check_eq("c3_out_ch", 64'(out_ch3), 64'(exp3_ch[i]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
